// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state and size-code encodings for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, MODIFY, DONE} state_t;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;
  localparam int SIGN_BIT = 3;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane extraction/extension for loads and lane merge for stores
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  sign_mask,
  input  logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misalign
);
  logic        is_byte, is_half, sgn;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext, wrep;
  logic [3:0]  be;
  assign is_byte = sign_mask[2:0] == SZ_BYTE;
  assign is_half = sign_mask[2:0] == SZ_HALF;
  assign sgn = sign_mask[SIGN_BIT];
  // any size code other than byte/half behaves as a word access
  assign misalign = is_half ? off[0] : (!is_byte && off != 2'd0);
  assign b = word[{off, 3'b000} +: 8];
  assign h = off[1] ? word[31:16] : word[15:0];
  assign ext = is_byte ? {{24{sgn & b[7]}}, b} : is_half ? {{16{sgn & h[15]}}, h} : word;
  assign load_data = misalign ? '0 : ext;
  assign wrep = is_byte ? {4{write_data[7:0]}} : is_half ? {2{write_data[15:0]}} : write_data;
  assign be = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      assign store_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end
  endgenerate
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory slave doing extended loads and read-modify-write stores
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned
);
  state_t            state, next;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rword, wd_q, ld, st;
  logic [IDX_W+1:0]  a_q;
  logic [3:0]        sm_q;
  logic              wr_q, req, mis;
  logic              unused_hi;
  assign unused_hi = ^addr[31:IDX_W+2];
  assign req = memread | memwrite;
  assign stall = (req && state == IDLE) || state == FETCH || state == MODIFY;
  mem_lane_align u_align (
    .word(rword),
    .off(a_q[1:0]),
    .sign_mask(sm_q),
    .write_data(wd_q),
    .load_data(ld),
    .store_word(st),
    .misalign(mis)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = req ? FETCH : IDLE;
      FETCH:   next = wr_q ? MODIFY : DONE;
      MODIFY:  next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      read_data  <= '0;
      misaligned <= 1'b0;
      a_q        <= '0;
      wd_q       <= '0;
      sm_q       <= '0;
      wr_q       <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        a_q  <= addr[IDX_W+1:0];
        wd_q <= write_data;
        sm_q <= sign_mask;
        wr_q <= memwrite;
      end
      if (state == FETCH) begin
        if (mis) misaligned <= 1'b1;
        if (!wr_q) read_data <= ld;
      end
    end
  end
  // write enable follows the reset state register, so a reset aborts a pending store
  always_ff @(posedge clk) begin
    if (state == IDLE) rword <= mem[addr[IDX_W+1:2]];
    if (state == MODIFY && !mis) mem[a_q[IDX_W+1:2]] <= st;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus against a word-array model with per-cycle output compare
module tb_data_mem_responder;
  import dmem_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic [31:0] addr = 0, write_data = 0;
  logic        memwrite = 0, memread = 0;
  logic [3:0]  sign_mask = 0;
  logic [31:0] read_data;
  logic        stall, misaligned;
  logic [31:0] exp_rd = 0;
  logic        exp_stall = 0, exp_mis = 0;
  logic [31:0] mm [1024];
  int checks = 0, fails = 0;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .stall(stall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks += 3;
    if (stall !== exp_stall) begin
      fails++;
      $display("FAIL cyc_stall t=%0t got=%b want=%b", $time, stall, exp_stall);
    end
    if (read_data !== exp_rd) begin
      fails++;
      $display("FAIL cyc_read_data t=%0t got=%h want=%h", $time, read_data, exp_rd);
    end
    if (misaligned !== exp_mis) begin
      fails++;
      $display("FAIL cyc_misaligned t=%0t got=%b want=%b", $time, misaligned, exp_mis);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] res, output bit mis);
    int idx, off;
    bit isb, ish;
    logic [31:0] wd, v;
    idx = int'(a[11:2]);
    off = int'(a[1:0]);
    isb = m[2:0] == 3'b001;
    ish = m[2:0] == 3'b011;
    mis = ish ? (off % 2 != 0) : (!isb && off != 0);
    wd = mm[idx];
    if (isb) begin
      v = (wd >> (8 * off)) & 32'hFF;
      if (m[3] && v[7]) v = v | 32'hFFFFFF00;
    end else if (ish) begin
      v = (wd >> (8 * off)) & 32'hFFFF;
      if (m[3] && v[15]) v = v | 32'hFFFF0000;
    end else v = wd;
    res = mis ? 32'h0 : v;
    if (w && !mis) begin
      if (isb) wd[8*off +: 8] = d[7:0];
      else if (ish) wd[8*off +: 16] = d[15:0];
      else wd = d;
      mm[idx] = wd;
    end
  endtask

  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    logic [31:0] res;
    bit mis;
    int n;
    model(w, a, d, m, res, mis);
    memwrite = w; memread = r; addr = a; write_data = d; sign_mask = m;
    exp_stall = 1;
    n = w ? 3 : 2;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        if (mis) exp_mis = 1;
        if (!w) exp_rd = res;
      end
      if (k == n) exp_stall = 0;
    end
    @(posedge clk); #1;
    memwrite = 0; memread = 0;
  endtask

  initial begin
    #2;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    @(posedge clk); #1; rst_n = 1;
    access(1, 0, 32'h10, 32'hDEADBEEF, 4'b0111);
    access(0, 1, 32'h10, 0, 4'b0111);
    chk("ld_w_10", read_data, 32'hDEADBEEF);
    access(0, 1, 32'h13, 0, 4'b1001);
    chk("ld_bs_13", read_data, 32'hFFFFFFDE);
    access(0, 1, 32'h13, 0, 4'b0001);
    chk("ld_bu_13", read_data, 32'h000000DE);
    access(0, 1, 32'h10, 0, 4'b1011);
    chk("ld_hs_10", read_data, 32'hFFFFBEEF);
    access(1, 0, 32'h11, 32'h0000005A, 4'b0001);
    access(0, 1, 32'h10, 0, 4'b0111);
    chk("st_b_11", read_data, 32'hDEAD5AEF);
    access(1, 0, 32'h12, 32'h00001234, 4'b0011);
    access(0, 1, 32'h10, 0, 4'b0111);
    chk("st_h_12", read_data, 32'h12345AEF);
    access(1, 0, 32'h12, 32'hCAFEF00D, 4'b0111);
    chk("mis_set", {31'b0, misaligned}, 32'h1);
    access(0, 1, 32'h10, 0, 4'b0111);
    chk("mis_no_write", read_data, 32'h12345AEF);
    access(0, 1, 32'h11, 0, 4'b1011);
    chk("mis_ld_zero", read_data, 32'h0);
    access(1, 0, 32'h1000, 32'h11111111, 4'b0111);
    access(0, 1, 32'h0, 0, 4'b0111);
    chk("wrap", read_data, 32'h11111111);
    access(0, 1, 32'h10, 0, 4'b0000);
    chk("illegal_sz_word", read_data, 32'h12345AEF);
    access(0, 1, 32'h11, 0, 4'b1001);
    chk("ld_bs_pos", read_data, 32'h0000005A);
    access(0, 1, 32'h12, 0, 4'b0011);
    chk("ld_hu_12", read_data, 32'h00001234);
    access(1, 1, 32'h30, 32'h22222222, 4'b0111);
    chk("both_req_rd_kept", read_data, 32'h00001234);
    access(0, 1, 32'h30, 0, 4'b0111);
    chk("both_req_wrote", read_data, 32'h22222222);
    chk("mis_sticky", {31'b0, misaligned}, 32'h1);
    access(1, 0, 32'h20, 32'h0BADF00D, 4'b0111);
    memwrite = 1; addr = 32'h20; write_data = 32'hFFFFFFFF; sign_mask = 4'b0111;
    exp_stall = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("modify_stall", {31'b0, stall}, 32'h1);
    #1;
    rst_n = 0; memwrite = 0;
    exp_stall = 0; exp_rd = 0; exp_mis = 0;
    #1;
    chk("arst_stall", {31'b0, stall}, 32'h0);
    chk("arst_read_data", read_data, 32'h0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1; rst_n = 1;
    access(0, 1, 32'h20, 0, 4'b0111);
    chk("abort_no_write", read_data, 32'h0BADF00D);
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
